// File: rtl/logic_eval_pipe.sv
// rtl/logic_eval_pipe.sv - two-stage valid/ready X/Y lane evaluator with saturating lane-hit counters
// Stage 1 holds operands, stage 2 holds results; counters add lanes set in each consumed result.
module logic_eval_pipe #(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic [WIDTH-1:0]       C,
  input  logic [WIDTH-1:0]       D,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       X,
  output logic [WIDTH-1:0]       Y,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] x_count,
  output logic [COUNT_WIDTH-1:0] y_count
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = COUNT_WIDTH + PW + 1;

  function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  // Wide sum so any carry out of COUNT_WIDTH is seen and pinned to all-ones.
  function automatic logic [COUNT_WIDTH-1:0] sat_add(input logic [COUNT_WIDTH-1:0] cnt,
                                                     input logic [PW-1:0] inc);
    logic [SW-1:0] sum;
    sum = SW'(cnt) + SW'(inc);
    if (sum[SW-1:COUNT_WIDTH] != '0) return '1;
    return sum[COUNT_WIDTH-1:0];
  endfunction

  logic                   s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       x_q, x_d, y_q, y_d;
  logic [COUNT_WIDTH-1:0] x_count_q, x_count_d, y_count_q, y_count_d;
  logic                   s2_load, accept, consume;

  always_comb begin
    s2_load     = s1_valid_q & (~out_valid_q | out_ready);
    in_ready    = ~s1_valid_q | s2_load;
    accept      = in_valid & in_ready;
    consume     = out_valid_q & out_ready;

    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    x_count_d   = x_count_q;
    y_count_d   = y_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = A;
      b_d        = B;
      c_d        = C;
      d_d        = D;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      out_valid_d = 1'b1;
      x_d         = a_q & (~b_q | c_q);
      y_d         = (~b_q & c_q) | (~(a_q & d_q) & (b_q | c_q));
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      x_count_d = '0;
      y_count_d = '0;
    end else if (consume) begin
      x_count_d = sat_add(x_count_q, popcount(x_q));
      y_count_d = sat_add(y_count_q, popcount(y_q));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      x_count_q   <= '0;
      y_count_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_count_q   <= x_count_d;
      y_count_q   <= y_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign X         = x_q;
  assign Y         = y_q;
  assign x_count   = x_count_q;
  assign y_count   = y_count_q;

endmodule

// File: tb/tb_logic_eval_pipe.sv
// tb/tb_logic_eval_pipe.sv - randomized and directed bench for logic_eval_pipe against a queue model
// Two instances share stimulus: default counters and 4-bit counters for saturation.
module tb_logic_eval_pipe;

  logic        clock = 1'b0;
  logic        reset, in_valid, out_ready, clear;
  logic [7:0]  A, B, C, D;
  logic        in_ready, out_valid, in_ready_s, out_valid_s;
  logic [7:0]  X, Y, X_s, Y_s;
  logic [15:0] x_count, y_count;
  logic [3:0]  x_count_s, y_count_s;

  int vectors = 0;
  int errs    = 0;

  logic_eval_pipe #(.WIDTH(8), .COUNT_WIDTH(16)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .C(C), .D(D), .out_valid(out_valid), .out_ready(out_ready),
    .X(X), .Y(Y), .clear(clear), .x_count(x_count), .y_count(y_count)
  );

  logic_eval_pipe #(.WIDTH(8), .COUNT_WIDTH(4)) u_sat (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(A), .B(B), .C(C), .D(D), .out_valid(out_valid_s), .out_ready(out_ready),
    .X(X_s), .Y(Y_s), .clear(clear), .x_count(x_count_s), .y_count(y_count_s)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: words accepted but not yet consumed, in order.
  typedef struct { logic [7:0] x; logic [7:0] y; int acc; } res_t;
  res_t q[$];
  int   edge_cnt = 0;
  int   mx16 = 0, my16 = 0, mx4 = 0, my4 = 0;

  function automatic logic [7:0] fx(input logic [7:0] a, b, c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[i] && (!b[i] || c[i]);
    return r;
  endfunction

  function automatic logic [7:0] fy(input logic [7:0] a, b, c, d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (!b[i] && c[i]) || (!(a[i] && d[i]) && (b[i] || c[i]));
    return r;
  endfunction

  function automatic int sat(input int cnt, input int inc, input int mx);
    return (cnt + inc > mx) ? mx : cnt + inc;
  endfunction

  // Head of queue is presented once it has spent at least one edge in the pipe.
  function automatic bit m_vis();
    return q.size() > 0 && q[0].acc < edge_cnt;
  endfunction

  function automatic bit m_rdy();
    return q.size() < 2 || out_ready;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
      mx16 = 0; my16 = 0; mx4 = 0; my4 = 0;
    end else begin
      bit cons, acc;
      cons = m_vis() && out_ready;
      acc  = in_valid && m_rdy();
      if (clear) begin
        mx16 = 0; my16 = 0; mx4 = 0; my4 = 0;
      end else if (cons) begin
        mx16 = sat(mx16, $countones(q[0].x), 65535);
        my16 = sat(my16, $countones(q[0].y), 65535);
        mx4  = sat(mx4,  $countones(q[0].x), 15);
        my4  = sat(my4,  $countones(q[0].y), 15);
      end
      if (cons) void'(q.pop_front());
      edge_cnt++;
      if (acc) q.push_back('{fx(A, B, C), fy(A, B, C, D), edge_cnt});
    end
  end

  always @(negedge clock) begin
    bit ev;
    ev = m_vis();
    chk("out_valid", out_valid, ev);
    chk("out_valid_s", out_valid_s, ev);
    chk("in_ready", in_ready, m_rdy());
    chk("in_ready_s", in_ready_s, m_rdy());
    if (ev) begin
      chk("X", X, q[0].x);
      chk("Y", Y, q[0].y);
      chk("X_s", X_s, q[0].x);
      chk("Y_s", Y_s, q[0].y);
    end else if (reset) begin
      chk("X_rst", X, 0);
      chk("Y_rst", Y, 0);
    end
    chk("x_count", x_count, mx16);
    chk("y_count", y_count, my16);
    chk("x_count_s", x_count_s, mx4);
    chk("y_count_s", y_count_s, my4);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] a, b, c, d, input bit ordy, input bit clr);
    in_valid  = v;
    A = a; B = b; C = c; D = d;
    out_ready = ordy;
    clear     = clr;
  endtask

  initial begin
    int         idx, guard;
    bit         held;
    logic [7:0] w [4];
    logic [3:0] sat_exp [3];

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    chk("pin_fx_ff", fx(8'hFF, 8'h00, 8'h00), 8'hFF);
    chk("pin_fy_ff", fy(8'hFF, 8'h00, 8'h00, 8'h00), 8'h00);
    chk("pin_fx_0f", fx(8'h0F, 8'hF0, 8'h3C), 8'h0F);
    chk("pin_fy_0f", fy(8'h0F, 8'hF0, 8'h3C, 8'hFF), 8'hFC);

    step(); step();
    reset = 1'b0;
    #1;
    chk("lit_rst_in_ready", in_ready, 1);
    chk("lit_rst_out_valid", out_valid, 0);
    chk("lit_rst_x_count", x_count, 0);

    drive(1, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (3) step();
    chk("lit_single_x", x_count, 8);
    chk("lit_single_x_s", x_count_s, 8);

    clear = 1'b1; step(); clear = 1'b0;
    repeat (3) begin
      drive(1, 8'h0F, 8'hF0, 8'h3C, 8'hFF, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (3) step();
    chk("lit_stream_x", x_count, 12);
    chk("lit_stream_y", y_count, 18);
    chk("lit_stream_x_s", x_count_s, 12);
    chk("lit_stream_y_s", y_count_s, 15);

    clear = 1'b1; step(); clear = 1'b0;
    w[0] = 8'h13; w[1] = 8'h6A; w[2] = 8'hC5; w[3] = 8'h9E;
    idx = 0;
    repeat (6) begin
      drive(1, w[idx], ~w[idx], w[idx] >> 1, w[idx], 0, 0);
      #1;
      if (in_ready) idx++;
      step();
    end
    chk("lit_stall_accepts", idx, 2);
    chk("lit_stall_in_ready", in_ready, 0);
    guard = 0;
    while (idx < 4 && guard < 20) begin
      drive(1, w[idx], ~w[idx], w[idx] >> 1, w[idx], 1, 0);
      #1;
      if (in_ready) idx++;
      step();
      guard++;
    end
    chk("lit_stall_drain", idx, 4);
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (4) step();

    clear = 1'b1; step(); clear = 1'b0;
    sat_exp[0] = 4'd8; sat_exp[1] = 4'd15; sat_exp[2] = 4'd15;
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0);
      step();
      drive(0, 0, 0, 0, 0, 1, 0);
      repeat (3) step();
      chk("lit_sat_x_s", x_count_s, sat_exp[k]);
    end
    drive(1, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    step();
    clear = 1'b1; step(); clear = 1'b0;
    chk("lit_clear_consume_s", x_count_s, 0);
    chk("lit_clear_consume", x_count, 0);

    drive(1, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (3) step();
    drive(1, 8'hA5, 8'h0F, 8'h3C, 8'h55, 0, 0);
    step();
    drive(1, 8'h5A, 8'hF0, 8'hC3, 8'hAA, 0, 0);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("lit_rst_flight_valid", out_valid, 0);
    chk("lit_rst_flight_x", x_count, 0);
    chk("lit_rst_flight_y", y_count_s, 0);
    step();
    reset = 1'b0;
    drive(1, 8'h3C, 8'h81, 8'h66, 8'h0F, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (4) step();
    chk("lit_rst_one_word_x", x_count, $countones(fx(8'h3C, 8'h81, 8'h66)));

    held = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!held) begin
        in_valid = ($urandom % 10) < 7;
        A = 8'($urandom); B = 8'($urandom); C = 8'($urandom); D = 8'($urandom);
      end
      out_ready = ($urandom % 10) < 6;
      clear     = ($urandom % 50) == 0;
      reset     = ($urandom % 300) == 0;
      #1;
      held = in_valid && !in_ready && !reset;
      step();
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 0);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
